// File: rtl/padd_pkg.sv
// rtl/padd_pkg.sv - shared defaults and stage types for pipelined_adder
// Contents: default WIDTH/STAGES, per-stage control payload, chunk-width helper.
package padd_pkg;

    localparam int PADD_WIDTH  = 32;
    localparam int PADD_STAGES = 4;

    // Per-stage control payload. The skewed operand chunks and the partial
    // sum live in WIDTH-sized arrays beside this struct in the top level,
    // because their width follows the instance parameters.
    typedef struct packed {
        logic valid;   // stage holds a live transaction
        logic carry;   // carry out of this stage's chunk
    } padd_ctrl_t;

    function automatic int padd_chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - one-bit full adder cell
// Ports: a, b, ci in; s sum, co carry out.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// rtl/rca_chunk.sv - combinational CW-bit ripple-carry chunk built from fa_cell
// Ports: A, B operand chunk; Cin carry in; S sum chunk; Cout carry out;
//        Cmsb carry into the chunk MSB (used for signed overflow).
module rca_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] A,
    input  logic [CW-1:0] B,
    input  logic          Cin,
    output logic [CW-1:0] S,
    output logic          Cout,
    output logic          Cmsb
);

    logic [CW:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < CW; i++) begin : g_bit
        fa_cell u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (S[i]),
            .co (c[i+1])
        );
    end

    assign Cout = c[CW];
    assign Cmsb = c[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep pipelined WIDTH-bit adder with valid/ready
// Ports: clk, rst (sync, active high); in_valid/in_ready, A, B, Cin operand side;
//        out_valid/out_ready, S, Cout result side; Ovf only when PADD_OVF_EN is defined.
// Optional feature macro: PADD_OVF_EN (signed overflow output).
module pipelined_adder
    import padd_pkg::*;
#(
    parameter int WIDTH  = PADD_WIDTH,
    parameter int STAGES = PADD_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
`ifdef PADD_OVF_EN
    output logic             Ovf,
`endif
    output logic             Cout
);

    localparam int CW = padd_chunk_w(WIDTH, STAGES);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CW{1'b1}});

    if ((WIDTH % STAGES) != 0 || STAGES < 1) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    // Stage registers. a_q/b_q carry the not-yet-added upper chunks forward,
    // s_q carries the finished lower chunks forward. Bits that are dead at a
    // given stage (already-consumed operands, not-yet-computed sum) are
    // constant and get trimmed by synthesis.
    padd_ctrl_t       ctrl_q [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES];
    logic [WIDTH-1:0] s_q    [STAGES];

    // Inputs seen by each stage and its next-state values.
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_s   [STAGES];
    logic             st_c   [STAGES];
    logic             st_v   [STAGES];
    logic [WIDTH-1:0] s_d    [STAGES];
    logic [CW-1:0]    ch_s   [STAGES];
    logic             ch_co  [STAGES];
    logic             ch_cm  [STAGES];

    logic adv;

    // One global advance: the whole pipe moves only when the result slot is
    // empty or being drained, so bubbles are kept and nothing is overwritten.
    assign adv       = !ctrl_q[STAGES-1].valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = ctrl_q[STAGES-1].valid;
    assign S         = s_q[STAGES-1];
    assign Cout      = ctrl_q[STAGES-1].carry;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign st_a[k] = A;
            assign st_b[k] = B;
            assign st_s[k] = '0;
            assign st_c[k] = Cin;
            assign st_v[k] = in_valid;
        end else begin : g_rest
            assign st_a[k] = a_q[k-1];
            assign st_b[k] = b_q[k-1];
            assign st_s[k] = s_q[k-1];
            assign st_c[k] = ctrl_q[k-1].carry;
            assign st_v[k] = ctrl_q[k-1].valid;
        end

        rca_chunk #(
            .CW (CW)
        ) u_chunk (
            .A    (st_a[k][k*CW +: CW]),
            .B    (st_b[k][k*CW +: CW]),
            .Cin  (st_c[k]),
            .S    (ch_s[k]),
            .Cout (ch_co[k]),
            .Cmsb (ch_cm[k])
        );

        // Splice this stage's sum chunk into the forwarded partial sum.
        assign s_d[k] = (st_s[k] & ~(CHUNK_MASK << (k*CW)))
                      | (WIDTH'(ch_s[k]) << (k*CW));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                s_q[k]    <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k].valid <= st_v[k];
                ctrl_q[k].carry <= ch_co[k];
                a_q[k]          <= st_a[k];
                b_q[k]          <= st_b[k];
                s_q[k]          <= s_d[k];
            end
        end
    end

`ifdef PADD_OVF_EN
    // Carry into the top bit, captured alongside Cout so Ovf shares its timing.
    logic msb_c_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            msb_c_q <= 1'b0;
        end else if (adv) begin
            msb_c_q <= ch_cm[STAGES-1];
        end
    end

    assign Ovf = msb_c_q ^ ctrl_q[STAGES-1].carry;
`else
    logic unused_cmsb;
    assign unused_cmsb = ch_cm[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder at STAGES 4, 1 and 32
module tb_pipelined_adder;

    localparam int W = 32;
    localparam int STG [3] = '{4, 1, 32};

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        int           cyc;
        bit           chk_lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A, B;
    logic         Cin;
    logic         irdy [3];
    logic         ov   [3];
    logic         ordy [3];
    logic [W-1:0] s    [3];
    logic         co   [3];
    logic         ovf  [3];

    exp_t sbq [3][$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   bp_phase = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar d = 0; d < 3; d++) begin : g_dut
        pipelined_adder #(
            .WIDTH  (W),
            .STAGES (STG[d])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (irdy[d]),
            .A         (A),
            .B         (B),
            .Cin       (Cin),
            .out_valid (ov[d]),
            .out_ready (ordy[d]),
            .S         (s[d]),
`ifdef PADD_OVF_EN
            .Ovf       (ovf[d]),
`endif
            .Cout      (co[d])
        );
`ifndef PADD_OVF_EN
        assign ovf[d] = 1'b0;
`endif
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference model: plain wide arithmetic and sign rules.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.s    = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        e.cyc  = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    // Monitor: all sampling at the falling edge, inputs change just after rising edges.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                sbq[d].delete();
            end else begin
                if (ov[d] && ordy[d]) begin
                    if (sbq[d].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_output dut%0d: got S=%h with nothing outstanding", d, s[d]);
                    end else begin
                        e = sbq[d].pop_front();
                        chk($sformatf("S_dut%0d", d), 64'(s[d]), 64'(e.s));
                        chk($sformatf("Cout_dut%0d", d), 64'(co[d]), 64'(e.cout));
`ifdef PADD_OVF_EN
                        chk($sformatf("Ovf_dut%0d", d), 64'(ovf[d]), 64'(e.ovf));
`endif
                        if (e.chk_lat)
                            chk($sformatf("latency_dut%0d", d), 64'(cyc - e.cyc), 64'(STG[d]));
                    end
                end
                if (in_valid && irdy[d]) begin
                    e = model(A, B, Cin);
                    e.cyc = cyc;
                    e.chk_lat = !bp_phase || (d != 0);
                    sbq[d].push_back(e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand;
        A   = $urandom;
        B   = $urandom;
        Cin = 1'($urandom_range(0, 1));
    endtask

    task automatic direct(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        A = a; B = b; Cin = c; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        chk("dir_valid", 64'(ov[0]), 64'd1);
        chk("dir_S", 64'(s[0]), 64'(es));
        chk("dir_Cout", 64'(co[0]), 64'(ec));
`ifdef PADD_OVF_EN
        chk("dir_Ovf", 64'(ovf[0]), 64'(eo));
`else
        if (eo === 1'bx) $display("note: unknown overflow expectation");
`endif
        repeat (40) tick;
    endtask

    initial begin
        logic [W-1:0] hs;
        logic         hc;
        bit           empty;

        rst = 1'b1; in_valid = 1'b1; A = '1; B = '1; Cin = 1'b1;
        ordy[0] = 1'b0; ordy[1] = 1'b1; ordy[2] = 1'b0;
        tick;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("rst_out_valid_dut%0d", d), 64'(ov[d]), 64'd0);
                chk($sformatf("rst_S_dut%0d", d), 64'(s[d]), 64'd0);
                chk($sformatf("rst_Cout_dut%0d", d), 64'(co[d]), 64'd0);
                chk($sformatf("rst_in_ready_dut%0d", d), 64'(irdy[d]), 64'd1);
            end
            if (r == 0) tick;
        end
        tick;
        rst = 1'b0; in_valid = 1'b0;
        for (int d = 0; d < 3; d++) ordy[d] = 1'b1;
        repeat (40) tick;

        direct(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        direct(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
        direct(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

        // Streaming: 8 back-to-back random transfers.
        for (int i = 0; i < 8; i++) begin
            set_rand;
            in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        repeat (40) tick;

        // Backpressure on the 4-stage instance while operands keep arriving.
        bp_phase = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_rand;
            in_valid = 1'b1;
            ordy[0] = !(i >= 6 && i < 9);
            if (i >= 6 && i < 9) begin
                @(negedge clk);
                chk("bp_out_valid", 64'(ov[0]), 64'd1);
                chk("bp_in_ready", 64'(irdy[0]), 64'd0);
                if (i == 6) begin
                    hs = s[0];
                    hc = co[0];
                end else begin
                    chk("bp_S_held", 64'(s[0]), 64'(hs));
                    chk("bp_Cout_held", 64'(co[0]), 64'(hc));
                end
            end
            tick;
        end
        ordy[0] = 1'b1;
        in_valid = 1'b0;
        repeat (40) tick;
        bp_phase = 1'b0;

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            set_rand;
            in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("midrst_out_valid_dut%0d", d), 64'(ov[d]), 64'd0);
        repeat (40) tick;

        // Final streaming burst then drain.
        for (int i = 0; i < 8; i++) begin
            set_rand;
            in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        empty = 1'b0;
        for (int i = 0; i < 100 && !empty; i++) begin
            tick;
            empty = (sbq[0].size() == 0) && (sbq[1].size() == 0) && (sbq[2].size() == 0);
        end
        chk("drain_all_results", 64'(empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
